lcd_timing_driver: RTL

Panel-side timing generator and pixel sink for the RGB LCD path. It runs horizontal and vertical counters on the pixel clock and drives the panel's sync, data-enable and RGB lines. It also presents 1-based `x_pos`/`y_pos` coordinates one cycle ahead of data-enable, so a registered pixel source such as the font/glyph renderer returns `pixel_data` exactly when the panel samples it. A run/stop state machine starts and stops scan-out only on frame boundaries.

---
 rtl/lcd_timing_pkg.sv | 26 ++
 rtl/lcd_timing_driver_if.sv | 26 ++
 rtl/lcd_colorbar_gen.sv | 37 +++
 rtl/lcd_timing_driver.sv | 135 +++++++++++++
 4 files changed

// File: rtl/lcd_timing_pkg.sv
// Shared definitions for the LCD timing path: default 480x272 panel timing,
// scan-out state encoding and the colour-bar palette used by the test pattern.
package lcd_timing_pkg;

    localparam int H_SYNC_DEF  = 41;
    localparam int H_BACK_DEF  = 2;
    localparam int H_DISP_DEF  = 480;
    localparam int H_FRONT_DEF = 2;
    localparam int V_SYNC_DEF  = 10;
    localparam int V_BACK_DEF  = 2;
    localparam int V_DISP_DEF  = 272;
    localparam int V_FRONT_DEF = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } lcd_state_e;

    // Bar 0 is the left-most bar: white, yellow, cyan, green, magenta, red, blue, black.
    localparam logic [7:0][23:0] BAR_TABLE = {
        24'h000000, 24'h0000FF, 24'hFF0000, 24'hFF00FF,
        24'h00FF00, 24'h00FFFF, 24'hFFFF00, 24'hFFFFFF
    };

endpackage

// File: rtl/lcd_timing_driver_if.sv
// Pixel-source handshake and panel-side lines of the LCD timing driver.
// master: the timing driver; slave: the pixel source / panel side.
interface lcd_timing_driver_if;

    logic        disp_en;
    logic [23:0] pixel_data;
    logic        data_req;
    logic [10:0] x_pos;
    logic [10:0] y_pos;
    logic        lcd_hs;
    logic        lcd_vs;
    logic        lcd_de;
    logic [23:0] lcd_rgb;
    logic        frame_start;

    modport master (
        input  disp_en, pixel_data,
        output data_req, x_pos, y_pos, lcd_hs, lcd_vs, lcd_de, lcd_rgb, frame_start
    );

    modport slave (
        output disp_en, pixel_data,
        input  data_req, x_pos, y_pos, lcd_hs, lcd_vs, lcd_de, lcd_rgb, frame_start
    );

endinterface

// File: rtl/lcd_colorbar_gen.sv
// Eight equal-width vertical colour bars selected by the 1-based column.
// The colour is registered so it lines up with the registered data enable.
module lcd_colorbar_gen
    import lcd_timing_pkg::*;
#(
    parameter int H_DISP = H_DISP_DEF
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [10:0] x_pos_i,
    input  logic        data_req_i,
    output logic [23:0] color_o
);

    localparam logic [13:0] H_DISP_C = 14'(H_DISP);

    logic [13:0] quot;
    logic [2:0]  bar_idx;
    logic [23:0] color_d;
    logic [23:0] color_q;

    // Map column 1..H_DISP onto bar 0..7; outside data_req the bar is black.
    always_comb begin
        quot    = (({3'd0, x_pos_i} - 14'd1) * 14'd8) / H_DISP_C;
        bar_idx = 3'(quot);
        color_d = data_req_i ? BAR_TABLE[bar_idx] : 24'h000000;
    end

    // One-cycle delay to match the coordinate-to-pixel latency.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) color_q <= 24'h000000;
        else       color_q <= color_d;
    end

    assign color_o = color_q;

endmodule

// File: rtl/lcd_timing_driver.sv
// LCD panel timing generator and pixel sink.
// Coordinates are presented one cycle ahead of lcd_de so a registered pixel
// source returns pixel_data exactly when the panel samples it. Scan-out only
// starts and stops on frame boundaries.
// Build option: define LCD_TEST_PATTERN_EN to replace pixel_data with an
// internally generated 8-bar colour pattern.
module lcd_timing_driver
    import lcd_timing_pkg::*;
#(
    parameter int H_SYNC  = H_SYNC_DEF,
    parameter int H_BACK  = H_BACK_DEF,
    parameter int H_DISP  = H_DISP_DEF,
    parameter int H_FRONT = H_FRONT_DEF,
    parameter int V_SYNC  = V_SYNC_DEF,
    parameter int V_BACK  = V_BACK_DEF,
    parameter int V_DISP  = V_DISP_DEF,
    parameter int V_FRONT = V_FRONT_DEF
) (
    input  logic                lcd_clk,
    input  logic                sys_rst,
    lcd_timing_driver_if.master lcd_bus
);

    localparam logic [10:0] H_TOTAL_C = 11'(H_SYNC + H_BACK + H_DISP + H_FRONT);
    localparam logic [10:0] V_TOTAL_C = 11'(V_SYNC + V_BACK + V_DISP + V_FRONT);
    localparam logic [10:0] H_SYNC_C  = 11'(H_SYNC);
    localparam logic [10:0] V_SYNC_C  = 11'(V_SYNC);
    localparam logic [10:0] H_DS_C    = 11'(H_SYNC + H_BACK);
    localparam logic [10:0] V_DS_C    = 11'(V_SYNC + V_BACK);
    localparam logic [10:0] H_REQ_LO  = 11'(H_SYNC + H_BACK - 1);
    localparam logic [10:0] H_REQ_HI  = 11'(H_SYNC + H_BACK + H_DISP - 1);
    localparam logic [10:0] V_ACT_HI  = 11'(V_SYNC + V_BACK + V_DISP);

    lcd_state_e  state_q, state_d;
    logic [10:0] h_cnt_q, h_cnt_d;
    logic [10:0] v_cnt_q, v_cnt_d;
    logic        de_q;

    logic        h_last, v_last, frame_last, running;
    logic        data_req, hs, vs, frame_start;
    logic [10:0] x_pos, y_pos;
    logic [23:0] pix_src;

    assign h_last     = (h_cnt_q == H_TOTAL_C - 11'd1);
    assign v_last     = (v_cnt_q == V_TOTAL_C - 11'd1);
    assign frame_last = h_last && v_last;

    // State register.
    always_ff @(posedge lcd_clk or posedge sys_rst) begin
        if (sys_rst) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Next state: leave RUN at any time, but only drop to IDLE once the frame is done.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (lcd_bus.disp_en)  state_d = RUN;
            RUN:     if (!lcd_bus.disp_en) state_d = STOP;
            STOP: begin
                if (frame_last)           state_d = IDLE;
                else if (lcd_bus.disp_en) state_d = RUN;
            end
            default: state_d = IDLE;
        endcase
    end

    // State-derived outputs: syncs, coordinate request and frame marker.
    always_comb begin
        running     = (state_q == RUN) || (state_q == STOP);
        hs          = !(running && (h_cnt_q < H_SYNC_C));
        vs          = !(running && (v_cnt_q < V_SYNC_C));
        frame_start = (state_q == RUN) && (h_cnt_q == 11'd0) && (v_cnt_q == 11'd0);
        data_req    = running
                      && (v_cnt_q >= V_DS_C)   && (v_cnt_q < V_ACT_HI)
                      && (h_cnt_q >= H_REQ_LO) && (h_cnt_q < H_REQ_HI);
        x_pos       = data_req ? (h_cnt_q - H_DS_C + 11'd2) : 11'd0;
        y_pos       = data_req ? (v_cnt_q - V_DS_C + 11'd1) : 11'd0;
    end

    // Counter next values: held at the origin in IDLE, raster scan otherwise.
    always_comb begin
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        if (state_q == IDLE) begin
            h_cnt_d = 11'd0;
            v_cnt_d = 11'd0;
        end else if (h_last) begin
            h_cnt_d = 11'd0;
            v_cnt_d = v_last ? 11'd0 : v_cnt_q + 11'd1;
        end else begin
            h_cnt_d = h_cnt_q + 11'd1;
        end
    end

    // Counter and data-enable registers.
    always_ff @(posedge lcd_clk or posedge sys_rst) begin
        if (sys_rst) begin
            h_cnt_q <= 11'd0;
            v_cnt_q <= 11'd0;
            de_q    <= 1'b0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
            de_q    <= data_req;
        end
    end

`ifdef LCD_TEST_PATTERN_EN
    logic unused_pixel_data;
    assign unused_pixel_data = ^lcd_bus.pixel_data;

    lcd_colorbar_gen #(
        .H_DISP (H_DISP)
    ) u_colorbar (
        .clk_i      (lcd_clk),
        .rst_i      (sys_rst),
        .x_pos_i    (x_pos),
        .data_req_i (data_req),
        .color_o    (pix_src)
    );
`else
    assign pix_src = lcd_bus.pixel_data;
`endif

    assign lcd_bus.data_req    = data_req;
    assign lcd_bus.x_pos       = x_pos;
    assign lcd_bus.y_pos       = y_pos;
    assign lcd_bus.lcd_hs      = hs;
    assign lcd_bus.lcd_vs      = vs;
    assign lcd_bus.lcd_de      = de_q;
    assign lcd_bus.lcd_rgb     = de_q ? pix_src : 24'h000000;
    assign lcd_bus.frame_start = frame_start;

endmodule
